// File: rtl/ca1d_engine.sv
// Clocked 1-D elementary cellular automaton engine.
// Programmable Wolfram rule, wrap/fixed edges, gen limit and fixed-point halt.
module ca1d_engine #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned CNT_W          = 16,
   parameter logic [7:0]  RULE_RESET     = 8'd30,
   parameter logic [7:0]  SEED_RESET     = 8'h10,
   parameter bit          HALT_ON_STABLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             rule_we,
   input  logic [7:0]       rule_in,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   input  logic             wrap,
   input  logic             boundary_val,
   input  logic [CNT_W-1:0] gen_limit,
   output logic [WIDTH-1:0] state_out,
   output logic [CNT_W-1:0] gen_count,
   output logic             busy,
   output logic             done,
   output logic             stable
);

   localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED_RESET);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fsm_t;

   fsm_t             fsm;
   logic [7:0]       rule;
   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH+1:0] ext;
   logic [CNT_W-1:0] cnt_nxt;
   logic             same;
   logic             halt;
   logic             lft;
   logic             rgt;

   // ext[0] is the virtual right neighbour of cell 0, ext[WIDTH+1] the
   // virtual left neighbour of cell WIDTH-1; cell i sees ext[i+2:i].
   always_comb begin
      lft = wrap ? state[0] : boundary_val;
      rgt = wrap ? state[WIDTH-1] : boundary_val;
      ext = {lft, state, rgt};
      nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         nxt[i] = rule[ext[i+2 -: 3]];
      end
   end

   always_comb begin
      same    = (nxt == state);
      cnt_nxt = (&gen_count) ? gen_count : gen_count + CNT_W'(1);
      halt    = ((gen_limit != '0) && (cnt_nxt == gen_limit))
             || (HALT_ON_STABLE && same);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         rule      <= RULE_RESET;
         state     <= SEED_W;
         gen_count <= '0;
         stable    <= 1'b0;
      end else begin
         if (rule_we) begin
            rule <= rule_in;
         end
         if (load) begin
            state     <= seed;
            gen_count <= '0;
            stable    <= 1'b0;
            fsm       <= IDLE;
         end else begin
            unique case (fsm)
               IDLE: begin
                  if (start) begin
                     fsm <= RUN;
                  end else if (step) begin
                     state     <= nxt;
                     gen_count <= cnt_nxt;
                     stable    <= same;
                     if (halt) begin
                        fsm <= DONE;
                     end
                  end
               end
               RUN: begin
                  if (stop) begin
                     fsm <= IDLE;
                  end else begin
                     state     <= nxt;
                     gen_count <= cnt_nxt;
                     stable    <= same;
                     if (halt) begin
                        fsm <= DONE;
                     end
                  end
               end
               DONE: begin
                  fsm <= DONE;
               end
               default: begin
                  fsm <= IDLE;
               end
            endcase
         end
      end
   end

   assign state_out = state;
   assign busy      = (fsm == RUN);
   assign done      = (fsm == DONE);

endmodule
